// File: rtl/tff_pkg.sv
// -----------------------------------------------------------------------------
// tff_pkg
//   Shared definitions for the time flip-flop (temporal accumulator) cell.
//   - RING_SEGS_DEFAULT : default number of one-hot ring segments.
//   - op_e              : decoded per-cycle operation on the token ring.
//   - onehot_to_count   : turns a one-hot ring image into the stored count
//                         (token position). It returns -1 when the image is
//                         not one-hot.
// -----------------------------------------------------------------------------
package tff_pkg;

  localparam int RING_SEGS_DEFAULT = 59;

  // Widest ring image that onehot_to_count accepts. Narrower rings are
  // zero-extended by the caller.
  localparam int MAX_SEGS = 1024;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2
  } op_e;

  function automatic int onehot_to_count(input logic [MAX_SEGS-1:0] v);
    int ones;
    int idx;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < MAX_SEGS; i++) begin
      if (v[i]) begin
        ones++;
        idx = i;
      end
    end
    return (ones == 1) ? idx : -1;
  endfunction

endpackage

// File: rtl/tff_ring.sv
// -----------------------------------------------------------------------------
// tff_ring
//   Bidirectional one-hot rotate register. The index of the single set bit is
//   the stored count.
//   Ports:
//     clk   in   system clock, rising edge
//     rstb  in   asynchronous active-low reset; token returns to segment 0
//     up    in   rotate token one segment up (count + 1, wraps at the top)
//     down  in   rotate token one segment down (count - 1, wraps at the bottom)
//     wrap  out  combinational: an up request while the token sits at the top
//     zero  out  combinational: the token sits at segment 0
//   The two requests are expected to be mutually exclusive. If both are
//   asserted the ring holds, so the token can never be duplicated or lost.
// -----------------------------------------------------------------------------
module tff_ring
  import tff_pkg::*;
#(
  parameter int SEGS = RING_SEGS_DEFAULT
) (
  input  logic clk,
  input  logic rstb,
  input  logic up,
  input  logic down,
  output logic wrap,
  output logic zero
);

  logic [SEGS-1:0] ring;
  logic [SEGS-1:0] ring_nxt;

  always_comb begin
    // NOTE: default assignment first, so every path assigns ring_nxt and no latch is inferred.
    ring_nxt = ring;
    if (up && !down) begin
      ring_nxt = {ring[SEGS-2:0], ring[SEGS-1]};
    end else if (down && !up) begin
      ring_nxt = {ring[0], ring[SEGS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: registers use non-blocking assignments, so every flop samples pre-edge values.
      ring <= {{(SEGS-1){1'b0}}, 1'b1};
    end else begin
      ring <= ring_nxt;
    end
  end

  assign wrap = up & ~down & ring[SEGS-1];
  assign zero = ring[0];

endmodule

// File: rtl/tff_accum.sv
// -----------------------------------------------------------------------------
// tff_accum
//   Time flip-flop. It accumulates WE-high time modulo RING_SEGS in a one-hot
//   token ring. It replays the stored time as an out pulse when RE is high,
//   and each replayed cycle consumes one count (destructive read).
//   Ports:
//     clk    in   system clock, rising edge
//     rstb   in   asynchronous active-low reset (ring to 0, outputs low)
//     WE     in   write enable: each sampled-high cycle adds 1
//     RE     in   read enable: each sampled-high cycle with a nonzero count
//                 emits one out cycle and subtracts 1
//     out    out  registered read-out pulse
//     carry  out  registered one-cycle pulse when a write wraps the ring
//   WE and RE high together is ignored. The state holds and both outputs
//   stay low.
// -----------------------------------------------------------------------------
module tff_accum
  import tff_pkg::*;
#(
  parameter int RING_SEGS = RING_SEGS_DEFAULT
) (
  input  logic clk,
  input  logic rstb,
  input  logic WE,
  input  logic RE,
  output logic out,
  output logic carry
);

  op_e  op;
  logic ring_wrap;
  logic ring_zero;

  // Enable decode. A read of an empty cell is turned into a hold here. The
  // ring therefore never underflows, and out stays low for that cycle.
  always_comb begin
    op = OP_HOLD;
    if (WE && !RE) begin
      op = OP_UP;
    end else if (RE && !WE && !ring_zero) begin
      op = OP_DOWN;
    end
  end

  tff_ring #(
    .SEGS (RING_SEGS)
  ) u_ring (
    .clk  (clk),
    .rstb (rstb),
    .up   (op == OP_UP),
    .down (op == OP_DOWN),
    .wrap (ring_wrap),
    .zero (ring_zero)
  );

  // out and carry come from disjoint operations, so they are never high
  // together.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out   <= 1'b0;
      carry <= 1'b0;
    end else begin
      out   <= (op == OP_DOWN);
      carry <= ring_wrap;
    end
  end

endmodule

// File: tb/tb_tff_accum.sv
// -----------------------------------------------------------------------------
// tb_tff_accum
//   Directed bench for tff_accum with RING_SEGS = 59. Inputs change on the
//   falling edge. Outputs are sampled on the next falling edge, which is half
//   a cycle after the rising edge that produced them. Per-window statistics
//   (out/carry counts and positions) are compared with hand-computed values.
// -----------------------------------------------------------------------------
module tb_tff_accum;
  import tff_pkg::*;

  localparam int SEGS = RING_SEGS_DEFAULT;

  logic clk;
  logic rstb;
  logic WE;
  logic RE;
  logic out;
  logic carry;

  int total;
  int bad;

  // statistics for the current window
  int out_cnt;
  int carry_cnt;
  int first_out;
  int last_out;
  int carry_at;
  int idx;
  int wr_idx;
  int both_cnt;

  tff_accum #(
    .RING_SEGS (SEGS)
  ) dut (
    .clk   (clk),
    .rstb  (rstb),
    .WE    (WE),
    .RE    (RE),
    .out   (out),
    .carry (carry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Observed count held in the DUT ring.
  function automatic int stored();
    logic [MAX_SEGS-1:0] v;
    v = '0;
    v[SEGS-1:0] = dut.u_ring.ring;
    return onehot_to_count(v);
  endfunction

  task automatic clear_stats();
    out_cnt   = 0;
    carry_cnt = 0;
    first_out = -1;
    last_out  = -1;
    carry_at  = -1;
    idx       = 0;
    wr_idx    = 0;
  endtask

  // Drive we/re for n cycles and sample each result on the falling edge.
  task automatic cyc(input logic we, input logic re, input int n);
    for (int i = 0; i < n; i++) begin
      WE = we;
      RE = re;
      @(posedge clk);
      @(negedge clk);
      if (we && !re) wr_idx++;
      if (out) begin
        out_cnt++;
        if (first_out < 0) first_out = idx;
        last_out = idx;
      end
      if (carry) begin
        carry_cnt++;
        carry_at = wr_idx;
      end
      if (out && carry) both_cnt++;
      idx++;
    end
    WE = 1'b0;
    RE = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    both_cnt = 0;
    WE       = 1'b0;
    RE       = 1'b0;
    rstb     = 1'b0;
    clear_stats();

    // reset state
    @(negedge clk);
    check("rst_out", int'(out), 0);
    check("rst_carry", int'(carry), 0);
    check("rst_stored", stored(), 0);
    rstb = 1'b1;

    // T0: read with nothing stored
    clear_stats();
    cyc(1'b0, 1'b1, 60);
    check("t0_out_cnt", out_cnt, 0);
    check("t0_carry_cnt", carry_cnt, 0);

    // T1: 5+7+3 writes, then a long read
    clear_stats();
    cyc(1'b1, 1'b0, 5); cyc(1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 7); cyc(1'b0, 1'b0, 2);
    cyc(1'b1, 1'b0, 3); cyc(1'b0, 1'b0, 2);
    check("t1_carry_cnt", carry_cnt, 0);
    check("t1_stored", stored(), 15);
    clear_stats();
    cyc(1'b0, 1'b1, 60);
    check("t1_out_cnt", out_cnt, 15);
    check("t1_first_out", first_out, 0);
    check("t1_last_out", last_out, 14);
    check("t1_stored_end", stored(), 0);

    // T2: exactly RING_SEGS writes wrap once, on the 59th write
    clear_stats();
    cyc(1'b1, 1'b0, 5);  cyc(1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 7);  cyc(1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 3);  cyc(1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 0);  cyc(1'b0, 1'b0, 1);
    cyc(1'b1, 1'b0, 43);
    check("t2_stored_58", stored(), 58);
    check("t2_carry_before", carry_cnt, 0);
    cyc(1'b1, 1'b0, 1);  cyc(1'b0, 1'b0, 1);
    check("t2_carry_cnt", carry_cnt, 1);
    check("t2_carry_at", carry_at, 59);
    check("t2_stored", stored(), 0);
    clear_stats();
    cyc(1'b0, 1'b1, 60);
    check("t2_out_cnt", out_cnt, 0);

    // T3: write 10, read 4, then read 20
    clear_stats();
    cyc(1'b1, 1'b0, 10);
    clear_stats();
    cyc(1'b0, 1'b1, 4);
    check("t3_out_a", out_cnt, 4);
    check("t3_stored_a", stored(), 6);
    cyc(1'b0, 1'b0, 1);
    clear_stats();
    cyc(1'b0, 1'b1, 20);
    check("t3_out_b", out_cnt, 6);
    check("t3_first_b", first_out, 0);
    check("t3_stored_b", stored(), 0);

    // T4: write 8, overlap ignored, then read
    clear_stats();
    cyc(1'b1, 1'b0, 8);
    clear_stats();
    cyc(1'b1, 1'b1, 5);
    check("t4_ovl_out", out_cnt, 0);
    check("t4_ovl_carry", carry_cnt, 0);
    check("t4_ovl_stored", stored(), 8);
    clear_stats();
    cyc(1'b0, 1'b1, 20);
    check("t4_out_cnt", out_cnt, 8);
    check("t4_last_out", last_out, 7);

    // T6: 61 writes wrap once and leave 2
    clear_stats();
    cyc(1'b1, 1'b0, 61);
    check("t6_carry_cnt", carry_cnt, 1);
    check("t6_carry_at", carry_at, 59);
    check("t6_stored", stored(), 2);
    clear_stats();
    cyc(1'b0, 1'b1, 5);
    check("t6_out_cnt", out_cnt, 2);

    // T5: write 20, reset asynchronously mid-read after 5 out cycles
    clear_stats();
    cyc(1'b1, 1'b0, 20);
    clear_stats();
    cyc(1'b0, 1'b1, 5);
    check("t5_out_cnt", out_cnt, 5);
    check("t5_stored_mid", stored(), 15);
    RE = 1'b1;
    check("t5_out_before", int'(out), 1);
    #2;
    rstb = 1'b0;
    #1;
    check("t5_rst_out", int'(out), 0);
    check("t5_rst_carry", int'(carry), 0);
    check("t5_rst_stored", stored(), 0);
    rstb = 1'b1;
    RE   = 1'b0;
    @(negedge clk);
    clear_stats();
    cyc(1'b0, 1'b1, 60);
    check("t5_after_out", out_cnt, 0);

    check("out_and_carry", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
